// File: rtl/perf_counter_pkg.sv
// Shared types and helpers for the performance counter bank.
package perf_counter_pkg;

  typedef enum logic {
    MODE_WRAP     = 1'b0,
    MODE_SATURATE = 1'b1
  } counter_mode_e;

  // Select width never drops to zero, so a single-channel bank still has a legal rd_sel port.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/counter_channel.sv
// One performance counter channel: live count, sticky overflow flag and snapshot shadow.
module counter_channel
  import perf_counter_pkg::*;
#(
  parameter int            WIDTH  = 32,
  parameter int            STEP_W = 4,
  parameter counter_mode_e MODE   = MODE_WRAP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [STEP_W-1:0] step,
  input  logic              clear,
  input  logic              snapshot,
  input  logic              ovf_clr,
  output logic [WIDTH-1:0]  count,
  output logic              ovf,
  output logic [WIDTH-1:0]  shadow
);

  logic [WIDTH:0]   sum;
  logic             carry;
  logic             ovf_event;
  logic [WIDTH-1:0] next_count;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sum        = {1'b0, count} + {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    carry      = sum[WIDTH];
    ovf_event  = enable & carry;
    next_count = count;
    if (enable) begin
      if (carry && (MODE == MODE_SATURATE)) begin
        next_count = '1;
      end else begin
        next_count = sum[WIDTH-1:0];
      end
    end
  end

  // NOTE: state uses non-blocking assignments so the snapshot sees count as it was before this edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count  <= '0;
      ovf    <= 1'b0;
      // NOTE: the shadow is plain flops, not a RAM, so resetting it is cheap and keeps readback defined.
      shadow <= '0;
    end else begin
      if (snapshot) begin
        shadow <= count;
      end
      if (clear) begin
        count <= '0;
        ovf   <= 1'b0;
      end else begin
        count <= next_count;
        if (ovf_event) begin
          ovf <= 1'b1;
        end else if (ovf_clr) begin
          ovf <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of independent event counters with atomic snapshot and a registered shadow readback port.
module perf_counter_bank
  import perf_counter_pkg::*;
#(
  parameter int            NUM_CH   = 4,
  parameter int            WIDTH    = 32,
  parameter int            STEP_W   = 4,
  parameter counter_mode_e MODE     = MODE_WRAP,
  localparam int           CH_SEL_W = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        enable,
  input  logic [NUM_CH*STEP_W-1:0] step,
  input  logic                     clear,
  input  logic                     snapshot,
  input  logic [NUM_CH-1:0]        ovf_clr,
  input  logic [CH_SEL_W-1:0]      rd_sel,
  output logic [NUM_CH*WIDTH-1:0]  count,
  output logic [NUM_CH-1:0]        ovf,
  output logic                     any_ovf,
  output logic [WIDTH-1:0]         rd_count
);

  logic [WIDTH-1:0] shadow [NUM_CH];
  logic [WIDTH-1:0] rd_next;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    counter_channel #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W),
      .MODE   (MODE)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable[i]),
      .step     (step[i*STEP_W +: STEP_W]),
      .clear    (clear),
      .snapshot (snapshot),
      .ovf_clr  (ovf_clr[i]),
      .count    (count[i*WIDTH +: WIDTH]),
      .ovf      (ovf[i]),
      .shadow   (shadow[i])
    );
  end

  assign any_ovf = |ovf;

  // Select codes beyond the last channel fall through to zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == CH_SEL_W'(i)) begin
        rd_next = shadow[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_count <= '0;
    end else begin
      rd_count <= rd_next;
    end
  end

endmodule
